// File: rtl/serial_add32_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add32_ctrl
// Description : Bit-serial adder/subtractor. One full-adder cell processes
//               one operand bit per clock, LSB first. Subtraction is A + ~B + 1.
//               The result and the flags are registered and change only when
//               an operation completes, or at reset.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               start      - begin operation (accepted in IDLE or DONE)
//               sub        - 0 = a+b, 1 = a-b (sampled with start)
//               a, b       - operands (sampled with start)
//               sum        - registered result
//               cout       - carry out (not-borrow when subtracting)
//               ovf        - signed overflow
//               zero       - result == 0
//               busy       - high while bits are being processed
//               done       - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add32_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic accept;
    logic last_bit;
    logic bit_s;
    logic bit_c;

    // start is only honoured when no operation is in flight
    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_bit = (state_q == S_RUN) && (cnt_q == LAST_CNT);

    // single full-adder cell on the current LSBs
    assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)   state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            res_d   = '0;
            carry_d = sub;      // the +1 of two's-complement subtraction
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {bit_s, res_q[WIDTH-1:1]};
            carry_d = bit_c;
            if (last_bit) begin
                // carry_q is the carry into the MSB on this final bit
                sum_d  = res_d;
                cout_d = bit_c;
                ovf_d  = carry_q ^ bit_c;
                zero_d = (res_d == '0);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add32_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add32_ctrl
// Description : Self-checking bench for serial_add32_ctrl (WIDTH=32).
//               Table of directed operations plus hand-written sequences for
//               reset, ignored start, back-to-back start and latency.
//               Latency is counted with the start-sampling edge as edge 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add32_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    serial_add32_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op_sub;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] exp_sum;
        logic        exp_c;
        logic        exp_v;
        logic        exp_z;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drive a start at the current time (caller is at a negedge), let the
    // start edge pass, then drop start and scramble the operand inputs.
    task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sub   = 1'($urandom_range(1));
    endtask

    // Called at a negedge; lat0 = edges already elapsed including the start edge.
    task automatic wait_done(input int lat0, output int lat, output int busy_cnt, output bit ok);
        lat      = lat0;
        busy_cnt = 0;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  lat;
        int  bcnt;
        bit  ok;
        int  done_seen;

        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;

        //                op   a             b             sum           c     v     z
        vecs[0] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset sum",  sum,  32'h0);
        chk("reset cout", cout, 1'b0);
        chk("reset ovf",  ovf,  1'b0);
        chk("reset zero", zero, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);

        // ---- start accepted on the first edge after reset release ----
        rst = 1'b0;
        launch(1'b0, 32'd3, 32'd4);
        chk("busy after first edge", busy, 1'b1);
        wait_done(1, lat, bcnt, ok);
        chk("first op completed", 32'(ok), 32'd1);
        chk("first op sum", sum, 32'd7);

        // ---- table-driven operations ----
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            launch(vecs[i].op_sub, vecs[i].op_a, vecs[i].op_b);
            wait_done(1, lat, bcnt, ok);
            chk($sformatf("vec%0d completed", i), 32'(ok), 32'd1);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd33);
            chk($sformatf("vec%0d busy cycles", i), 32'(bcnt), 32'd32);
            chk($sformatf("vec%0d sum", i), sum, vecs[i].exp_sum);
            chk($sformatf("vec%0d cout", i), cout, vecs[i].exp_c);
            chk($sformatf("vec%0d ovf", i), ovf, vecs[i].exp_v);
            chk($sformatf("vec%0d zero", i), zero, vecs[i].exp_z);
            chk($sformatf("vec%0d busy in done", i), busy, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d done one cycle", i), done, 1'b0);
        end

        // ---- start ignored mid-run, then back-to-back start in DONE ----
        @(negedge clk);
        launch(1'b0, 32'd3, 32'd4);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        // counter is now 5
        chk("sum held during run", sum, 32'h2345_6789);
        start = 1'b1;
        a     = 32'h0000_0100;
        b     = 32'h0000_0200;
        sub   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy after ignored start", busy, 1'b1);
        wait_done(7, lat, bcnt, ok);
        chk("ignored-start op completed", 32'(ok), 32'd1);
        chk("ignored-start latency", 32'(lat), 32'd33);
        chk("ignored-start sum", sum, 32'd7);
        chk("ignored-start cout", cout, 1'b0);
        // still in the DONE cycle: start again with 2+2
        chk("done high at b2b start", done, 1'b1);
        launch(1'b0, 32'd2, 32'd2);
        chk("b2b busy", busy, 1'b1);
        chk("b2b done dropped", done, 1'b0);
        chk("sum held in b2b run", sum, 32'd7);
        wait_done(1, lat, bcnt, ok);
        chk("b2b completed", 32'(ok), 32'd1);
        chk("b2b latency", 32'(lat), 32'd33);
        chk("b2b sum", sum, 32'd4);

        // ---- reset mid-run at counter 10 ----
        @(negedge clk);
        launch(1'b0, 32'hFFFF_0000, 32'h0001_0000);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        chk("midrst sum",  sum,  32'h0);
        chk("midrst cout", cout, 1'b0);
        chk("midrst ovf",  ovf,  1'b0);
        chk("midrst zero", zero, 1'b0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("midrst no done pulse", 32'(done_seen), 32'd0);
        launch(1'b0, 32'h1234_5678, 32'h1111_1111);
        wait_done(1, lat, bcnt, ok);
        chk("post-rst completed", 32'(ok), 32'd1);
        chk("post-rst sum", sum, 32'h2345_6789);
        chk("post-rst latency", 32'(lat), 32'd33);

        // ---- rst and start on the same edge ----
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'd1;
        b     = 32'd1;
        @(posedge clk);
        @(negedge clk);
        chk("rst+start busy", busy, 1'b0);
        chk("rst+start done", done, 1'b0);
        chk("rst+start sum", sum, 32'h0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst+start stays idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_add32_ctrl.md
SERIAL_ADD32_CTRL -- requirements
Module: serial_add32_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand width in bits (legal values 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation, sampled each rising edge.
REQ-005 The block SHALL have port sub, input, 1 bit: operation select, 0 = A+B, 1 = A-B; sampled with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands; sampled with start.
REQ-007 The block SHALL have port sum, output, WIDTH bits: registered result.
REQ-008 The block SHALL have ports cout, ovf and zero, output, 1 bit each: registered carry-out (the not-borrow flag when sub=1), signed overflow and result==0.
REQ-009 The block SHALL have ports busy and done, output, 1 bit each: operation in progress, and a one-cycle completion pulse.

Function
REQ-010 The block SHALL implement a 3-state FSM: IDLE, RUN and DONE.
REQ-011 A start sampled in IDLE or DONE SHALL cause the following on that edge:
- go to RUN;
- load a and b into internal shift registers;
- load b inverted when sub=1;
- set the carry flop to sub;
- clear the bit counter to 0.
REQ-012 At each edge in RUN, the block SHALL process exactly one bit, LSB first, with one full-adder cell:
- s = a0^b0^c;
- c_next = a0&b0 | c&(a0^b0);
- shift s into the MSB of the internal result shift register;
- shift both operand registers right by one;
- increment the counter.
REQ-013 At the RUN edge where the counter equals WIDTH-1, the block SHALL:
- copy the completed result to sum;
- set cout = final carry;
- set ovf = carry into MSB XOR final carry;
- set zero = (completed result == 0);
- go to DONE.
REQ-014 Latency SHALL be exactly WIDTH+1 rising edges from the start-sampling edge to the edge that asserts done (33 for WIDTH=32).
REQ-015 The block SHALL assert busy in RUN only, and done in DONE only; DONE SHALL last exactly one cycle.
REQ-016 From DONE with start=0, the block SHALL go to IDLE.
REQ-017 A start sampled in DONE SHALL be accepted (back-to-back operation), and done SHALL still be high for that cycle.
REQ-018 The block SHALL ignore start while in RUN: no reload and no effect on the current result.
REQ-019 sum, cout, ovf and zero SHALL change only at the completion edge (REQ-013) and at reset, and SHALL otherwise hold, including throughout a subsequent RUN.
REQ-020 The block SHALL ignore a, b and sub except on the edge where start is accepted.
REQ-021 The counter SHALL be ceil(log2(WIDTH)) bits wide, and SHALL neither wrap nor increment outside RUN.

Reset
REQ-022 While rst=1 at a rising edge, the block SHALL:
- go to IDLE;
- clear sum, cout, ovf, zero, busy, done, the counter, the carry flop and the shift registers to 0.
REQ-023 rst SHALL take priority over start on the same edge.
REQ-024 A reset mid-RUN SHALL abandon the operation with no done pulse, and the next accepted start SHALL compute correctly.
REQ-025 After reset release, the block SHALL accept start on the first edge with rst=0.

Verification
REQ-026 A bench SHALL cover add 0x00000001 + 0xFFFFFFFF -> sum=0x00000000, cout=1, zero=1, ovf=0, done high exactly 33 edges after the start edge, busy high for 32 cycles.
REQ-027 A bench SHALL cover add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, ovf=1, cout=0, zero=0.
REQ-028 A bench SHALL cover sub 0x00000005 - 0x00000007 -> sum=0xFFFFFFFE, cout=0, ovf=0; and sub 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-029 A bench SHALL cover start pulsed with new operands at counter=5 of a 3+4 add -> ignored, sum=0x00000007; then start held high during the DONE cycle with 2+2 -> accepted, done again 33 edges later with sum=0x00000004.
REQ-030 A bench SHALL cover rst asserted at counter=10 -> next cycle busy=0, done=0, sum=0, all flags 0, with no done pulse; then a subsequent 0x12345678 + 0x11111111 -> sum=0x23456789.
REQ-031 A bench SHALL cover rst and start high on the same edge -> state IDLE, busy stays 0.
